// File: rtl/lfsr_counter_bank.sv
// Bank of saturating up/down counters held as XNOR-LFSR states, for counting Bloom filters.
// Define LFSR_BANK_OCC_CNT_EN to build the nonzero-counter occupancy tracker on occ.
module lfsr_counter_bank #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned NCNT  = 16,
  localparam int unsigned IDXW = $clog2(NCNT),
  localparam int unsigned OCCW = $clog2(NCNT + 1)
) (
  input  logic            CLK,
  input  logic            rstb,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [1:0]      req_op,
  input  logic [IDXW-1:0] req_idx,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic            rsp_zero,
  output logic            rsp_sat,
  output logic            rsp_err,
  output logic [IDXW-1:0] rsp_idx,
  output logic [OCCW-1:0] occ
);

  typedef enum logic [1:0] {
    OpProbe = 2'b00,
    OpInc   = 2'b01,
    OpDec   = 2'b10,
    OpClear = 2'b11
  } op_e;

  function automatic logic [7:0] tap_mask(input int unsigned w);
    logic [7:0] m;
    case (w)
      4:       m = 8'b0000_1100;
      5:       m = 8'b0001_0100;
      6:       m = 8'b0011_0000;
      7:       m = 8'b0110_0000;
      default: m = 8'b1011_1000;
    endcase
    return m;
  endfunction

  localparam logic [7:0]       TapAll   = tap_mask(WIDTH);
  localparam logic [WIDTH-1:0] TapMask  = TapAll[WIDTH-1:0];
  // Taps other than the MSB; used to recover the bit shifted out on decrement.
  localparam logic [WIDTH-1:0] TapLo    = TapMask & {1'b0, {(WIDTH-1){1'b1}}};
  // The only state whose successor is zero: MSB set, everything else clear.
  localparam logic [WIDTH-1:0] SatState = {1'b1, {(WIDTH-1){1'b0}}};

  logic [WIDTH-1:0] cnt_q [NCNT];

  logic             rsp_valid_q;
  logic             rsp_zero_q;
  logic             rsp_sat_q;
  logic             rsp_err_q;
  logic [IDXW-1:0]  rsp_idx_q;

  op_e              op;
  logic             in_range;
  logic [WIDTH-1:0] cur;
  logic [WIDTH-1:0] inc_val;
  logic [WIDTH-1:0] dec_val;
  logic [WIDTH-1:0] nxt;
  logic             op_err;
  logic             accept;

  assign op        = op_e'(req_op);
  assign req_ready = !rsp_valid_q || rsp_ready;
  assign accept    = req_valid && req_ready;

  // Index decode doubles as the range check, so no out-of-range array read is ever made.
  always_comb begin
    cur      = '0;
    in_range = 1'b0;
    for (int unsigned i = 0; i < NCNT; i++) begin
      if (req_idx == IDXW'(i)) begin
        cur      = cnt_q[i];
        in_range = 1'b1;
      end
    end
  end

  always_comb begin
    inc_val = {cur[WIDTH-2:0], ~^(cur & TapMask)};
    dec_val = {~(cur[0] ^ (^({1'b0, cur[WIDTH-1:1]} & TapLo))), cur[WIDTH-1:1]};
  end

  always_comb begin
    nxt    = cur;
    op_err = 1'b0;
    unique case (op)
      OpProbe: nxt = cur;
      OpInc: begin
        if (cur == SatState) op_err = 1'b1;
        else                 nxt    = inc_val;
      end
      OpDec: begin
        if (cur == '0) op_err = 1'b1;
        else           nxt    = dec_val;
      end
      OpClear: nxt = '0;
      default: nxt = cur;
    endcase
    if (!in_range) begin
      nxt    = cur;
      op_err = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (rstb) begin
      for (int unsigned i = 0; i < NCNT; i++) begin
        cnt_q[i] <= '0;
      end
    end else if (accept) begin
      for (int unsigned i = 0; i < NCNT; i++) begin
        if (req_idx == IDXW'(i)) begin
          cnt_q[i] <= nxt;
        end
      end
    end
  end

  // Single-entry response register; a new accept overwrites it even while it is being drained.
  always_ff @(posedge CLK) begin
    if (rstb) begin
      rsp_valid_q <= 1'b0;
      rsp_zero_q  <= 1'b0;
      rsp_sat_q   <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_idx_q   <= '0;
    end else if (accept) begin
      rsp_valid_q <= 1'b1;
      rsp_zero_q  <= in_range && (nxt == '0);
      rsp_sat_q   <= in_range && (nxt == SatState);
      rsp_err_q   <= op_err;
      rsp_idx_q   <= req_idx;
    end else if (rsp_ready) begin
      rsp_valid_q <= 1'b0;
      rsp_zero_q  <= 1'b0;
      rsp_sat_q   <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_idx_q   <= '0;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_zero  = rsp_zero_q;
  assign rsp_sat   = rsp_sat_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_idx   = rsp_idx_q;

`ifdef LFSR_BANK_OCC_CNT_EN
  logic [OCCW-1:0] occ_q;
  logic [OCCW-1:0] occ_d;
  logic            occ_up;
  logic            occ_dn;

  always_comb begin
    occ_up = 1'b0;
    occ_dn = 1'b0;
    if (accept && in_range) begin
      unique case (op)
        OpInc:   occ_up = (cur == '0);
        OpDec:   occ_dn = (cur != '0) && (dec_val == '0);
        OpClear: occ_dn = (cur != '0);
        default: begin
          occ_up = 1'b0;
          occ_dn = 1'b0;
        end
      endcase
    end
    occ_d = occ_q;
    if (occ_up)      occ_d = occ_q + OCCW'(1);
    else if (occ_dn) occ_d = occ_q - OCCW'(1);
  end

  always_ff @(posedge CLK) begin
    if (rstb) occ_q <= '0;
    else      occ_q <= occ_d;
  end

  assign occ = occ_q;
`else
  assign occ = '0;
`endif

endmodule

// File: tb/tb_lfsr_counter_bank.sv
// Scoreboard bench for lfsr_counter_bank (WIDTH=4, NCNT=12): counters modelled as plain integers.
module tb_lfsr_counter_bank;

  localparam int W      = 4;
  localparam int NC     = 12;
  localparam int IW     = 4;
  localparam int OW     = 4;
  localparam int MaxCnt = (1 << W) - 2;

  logic          CLK = 1'b0;
  logic          rstb;
  logic          req_valid;
  logic          req_ready;
  logic [1:0]    req_op;
  logic [IW-1:0] req_idx;
  logic          rsp_valid;
  logic          rsp_ready;
  logic          rsp_zero;
  logic          rsp_sat;
  logic          rsp_err;
  logic [IW-1:0] rsp_idx;
  logic [OW-1:0] occ;

  lfsr_counter_bank #(
    .WIDTH(W),
    .NCNT (NC)
  ) dut (
    .CLK      (CLK),
    .rstb     (rstb),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_op   (req_op),
    .req_idx  (req_idx),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_zero (rsp_zero),
    .rsp_sat  (rsp_sat),
    .rsp_err  (rsp_err),
    .rsp_idx  (rsp_idx),
    .occ      (occ)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic          zero;
    logic          sat;
    logic          err;
    logic [IW-1:0] idx;
  } rsp_t;

  int   checks   = 0;
  int   failures = 0;
  int   mcnt[NC];
  int   last_wait;
  rsp_t sb[$];
  rsp_t mon_e;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int model_occ();
    int n = 0;
    for (int i = 0; i < NC; i++) if (mcnt[i] != 0) n++;
    return n;
  endfunction

  task automatic model_apply(input logic [1:0] op, input logic [IW-1:0] idx, output rsp_t r);
    r.idx = idx;
    if (int'(idx) >= NC) begin
      r.err  = 1'b1;
      r.zero = 1'b0;
      r.sat  = 1'b0;
    end else begin
      r.err = 1'b0;
      case (op)
        2'd1: if (mcnt[idx] == MaxCnt) r.err = 1'b1; else mcnt[idx]++;
        2'd2: if (mcnt[idx] == 0) r.err = 1'b1; else mcnt[idx]--;
        2'd3: mcnt[idx] = 0;
        default: ;
      endcase
      r.zero = (mcnt[idx] == 0);
      r.sat  = (mcnt[idx] == MaxCnt);
    end
  endtask

  task automatic send(input logic [1:0] op, input logic [IW-1:0] idx);
    rsp_t r;
    req_valid = 1'b1;
    req_op    = op;
    req_idx   = idx;
    last_wait = 0;
    forever begin
      @(negedge CLK);
      if (req_ready) break;
      last_wait++;
      if (last_wait > 50) begin
        check_eq("req_ready_timeout", req_ready, 1);
        req_valid = 1'b0;
        return;
      end
    end
    model_apply(op, idx, r);
    sb.push_back(r);
    @(posedge CLK);
    #1;
    req_valid = 1'b0;
`ifdef LFSR_BANK_OCC_CNT_EN
    check_eq("occ", occ, model_occ());
`else
    check_eq("occ_tied", occ, 0);
`endif
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_rsp_valid"}, rsp_valid, 0);
    check_eq({tag, "_rsp_zero"}, rsp_zero, 0);
    check_eq({tag, "_rsp_sat"}, rsp_sat, 0);
    check_eq({tag, "_rsp_err"}, rsp_err, 0);
    check_eq({tag, "_rsp_idx"}, rsp_idx, 0);
    check_eq({tag, "_occ"}, occ, 0);
    check_eq({tag, "_req_ready"}, req_ready, 1);
  endtask

  always @(negedge CLK) begin
    if (!rstb && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        check_eq("unexpected_rsp", rsp_valid, 0);
      end else begin
        mon_e = sb.pop_front();
        check_eq("rsp_zero", rsp_zero, mon_e.zero);
        check_eq("rsp_sat", rsp_sat, mon_e.sat);
        check_eq("rsp_err", rsp_err, mon_e.err);
        check_eq("rsp_idx", rsp_idx, mon_e.idx);
      end
    end
  end

  initial begin
    for (int i = 0; i < NC; i++) mcnt[i] = 0;
    rstb      = 1'b1;
    req_valid = 1'b0;
    req_op    = 2'd0;
    req_idx   = '0;
    rsp_ready = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    check_idle_outputs("reset");
    rstb = 1'b0;

    // Occupancy sequence: inc 1, inc 2, inc 2, clear 2.
    send(2'd1, 4'd1);
    send(2'd1, 4'd2);
    send(2'd1, 4'd2);
    send(2'd3, 4'd2);

    repeat (3) send(2'd1, 4'd3);
    send(2'd0, 4'd3);

    // Saturation: 14 increments reach SAT, the 15th is rejected.
    repeat (14) send(2'd1, 4'd0);
    send(2'd1, 4'd0);
    send(2'd0, 4'd0);

    send(2'd2, 4'd5);
    send(2'd1, 4'd5);
    send(2'd2, 4'd5);

    send(2'd1, 4'd13);
    send(2'd2, 4'd12);
    send(2'd3, 4'd15);
    send(2'd0, 4'd3);
    send(2'd0, 4'd0);
    send(2'd3, 4'd0);
    send(2'd2, 4'd0);

    for (int n = 0; n < 60; n++) begin
      send(2'($urandom_range(0, 3)), IW'($urandom_range(0, 13)));
    end
    repeat (3) @(posedge CLK);
    #1;

    // Backpressure: one response held, next request stalls with fields stable.
    rsp_ready = 1'b0;
    send(2'd1, 4'd4);
    req_valid = 1'b1;
    req_op    = 2'd1;
    req_idx   = 4'd4;
    repeat (3) begin
      @(negedge CLK);
      check_eq("stall_req_ready", req_ready, 0);
      check_eq("stall_rsp_valid", rsp_valid, 1);
      check_eq("stall_rsp_zero", rsp_zero, sb[0].zero);
      check_eq("stall_rsp_sat", rsp_sat, sb[0].sat);
      check_eq("stall_rsp_err", rsp_err, sb[0].err);
      check_eq("stall_rsp_idx", rsp_idx, sb[0].idx);
    end
    @(posedge CLK);
    #1;
    rsp_ready = 1'b1;
    send(2'd2, 4'd4);
    check_eq("release_wait", last_wait, 0);
    repeat (3) @(posedge CLK);
    #1;

    // Reset while a response is held.
    rsp_ready = 1'b0;
    send(2'd1, 4'd7);
    rstb = 1'b1;
    @(posedge CLK);
    #1;
    rstb = 1'b0;
    sb.delete();
    for (int i = 0; i < NC; i++) mcnt[i] = 0;
    rsp_ready = 1'b1;
    check_idle_outputs("midreset");
    for (int i = 0; i < NC; i++) send(2'd0, IW'(i));

    repeat (4) @(posedge CLK);
    #1;
    check_eq("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
